// File: rtl/dqn_fwd_engine.sv
// Time-multiplexed DQN forward pass: streamed input -> ReLU hidden layer -> output layer on one MAC,
// Q-values emitted on a valid/ready stream together with the greedy (argmax) action.
module dqn_fwd_engine #(
  parameter  int N_IN    = 9,
  parameter  int N_HID   = 5,
  parameter  int N_OUT   = 4,
  parameter  int DW      = 16,
  parameter  int FRAC    = 10,
  parameter  int ACC_W   = 40,
  parameter  int OUT_ACT = 0,
  localparam int AW      = $clog2(N_HID*N_IN + N_HID + N_OUT*N_HID + N_OUT),
  localparam int ACTW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic signed [DW-1:0] i_wr_data,
  output logic                 o_wr_err,
  input  logic                 i_start,
  output logic                 o_busy,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic signed [DW-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic signed [DW-1:0] o_out_data,
  output logic                 o_out_last,
  output logic [ACTW-1:0]      o_action,
  output logic                 o_done
);

  localparam int B2_BASE = N_HID*N_IN;
  localparam int W3_BASE = B2_BASE + N_HID;
  localparam int B3_BASE = W3_BASE + N_OUT*N_HID;
  localparam int DEPTH   = B3_BASE + N_OUT;
  localparam int CMAX0   = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CMAX    = ((CMAX0 > N_OUT) ? CMAX0 : N_OUT) + 2;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int NMAX    = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW      = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int XIW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HIW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HID, S_OUT, S_EMIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [NW-1:0]           r_neu;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [DW-1:0]    r_mem [0:DEPTH-1];
  logic signed [DW-1:0]    r_x   [0:N_IN-1];
  logic signed [DW-1:0]    r_a2  [0:N_HID-1];
  logic signed [DW-1:0]    r_q   [0:N_OUT-1];
  logic signed [DW-1:0]    r_best;
  logic [ACTW-1:0]         r_action;
  logic                    r_done, r_wr_err;

  int                      w_cnt_i, w_neu_i, w_mi, w_addr_i, w_mac_len;
  logic                    w_mac_state, w_bias_step, w_wb_step, w_last_neu, w_apply_relu;
  logic signed [DW-1:0]    w_rd, w_opnd, w_sat, w_wb;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_bias, w_shift;

  // Per neuron: step 0 loads the bias, steps 1..len accumulate, step len+1 writes back.
  always_comb begin
    w_cnt_i     = int'(r_cnt);
    w_neu_i     = int'(r_neu);
    w_mi        = w_cnt_i - 1;
    w_mac_state = (r_state == S_HID) || (r_state == S_OUT);
    w_mac_len   = (r_state == S_HID) ? N_IN : N_HID;
    w_bias_step = w_mac_state && (w_cnt_i == 0);
    w_wb_step   = w_mac_state && (w_cnt_i == w_mac_len + 1);
    w_last_neu  = (r_state == S_HID) ? (w_neu_i == N_HID-1) : (w_neu_i == N_OUT-1);
    if (r_state == S_HID)
      w_addr_i = (w_cnt_i == 0) ? B2_BASE + w_neu_i : w_neu_i*N_IN + w_mi;
    else
      w_addr_i = (w_cnt_i == 0) ? B3_BASE + w_neu_i : W3_BASE + w_neu_i*N_HID + w_mi;
    w_rd = '0;
    if (w_addr_i >= 0 && w_addr_i < DEPTH)
      w_rd = r_mem[AW'(w_addr_i)];
    w_opnd = '0;
    if (r_state == S_HID && w_mi >= 0 && w_mi < N_IN)
      w_opnd = r_x[XIW'(w_mi)];
    else if (r_state == S_OUT && w_mi >= 0 && w_mi < N_HID)
      w_opnd = r_a2[HIW'(w_mi)];
  end

  assign w_prod       = w_rd * w_opnd;
  assign w_bias       = ACC_W'(w_rd) <<< FRAC;
  assign w_shift      = r_acc >>> FRAC;
  assign w_apply_relu = (r_state == S_HID) || (OUT_ACT != 0);

  always_comb begin
    if (w_shift > SMAX)
      w_sat = {1'b0, {(DW-1){1'b1}}};
    else if (w_shift < SMIN)
      w_sat = {1'b1, {(DW-1){1'b0}}};
    else
      w_sat = w_shift[DW-1:0];
    w_wb = (w_apply_relu && w_sat < 0) ? '0 : w_sat;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_LOAD;
      S_LOAD: if (i_in_valid && w_cnt_i == N_IN-1) w_state_nxt = S_HID;
      S_HID:  if (w_wb_step && w_last_neu) w_state_nxt = S_OUT;
      S_OUT:  if (w_wb_step && w_last_neu) w_state_nxt = S_EMIT;
      S_EMIT: if (i_out_ready && w_cnt_i == N_OUT-1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Store has no reset so weights survive an aborted inference.
  always_ff @(posedge clk) begin
    if (i_wr_en && r_state == S_IDLE && int'(i_wr_addr) < DEPTH)
      r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_neu    <= '0;
      r_acc    <= '0;
      r_best   <= '0;
      r_action <= '0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      for (int i = 0; i < N_IN; i++)  r_x[i]  <= '0;
      for (int i = 0; i < N_HID; i++) r_a2[i] <= '0;
      for (int i = 0; i < N_OUT; i++) r_q[i]  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= i_wr_en && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_neu <= '0;
        end
        S_LOAD: begin
          if (i_in_valid) begin
            r_x[XIW'(r_cnt)] <= i_in_data;
            r_cnt <= (w_cnt_i == N_IN-1) ? '0 : r_cnt + 1'b1;
          end
        end
        S_HID, S_OUT: begin
          if (w_bias_step) begin
            r_acc <= w_bias;
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_wb_step) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            r_neu <= w_last_neu ? '0 : r_neu + 1'b1;
            if (r_state == S_HID) begin
              r_a2[HIW'(r_neu)] <= w_wb;
            end else begin
              r_q[ACTW'(r_neu)] <= w_wb;
              // Strict compare keeps the lowest index on ties.
              if (w_neu_i == 0 || w_wb > r_best) begin
                r_best   <= w_wb;
                r_action <= ACTW'(r_neu);
              end
            end
          end
        end
        S_EMIT: begin
          if (i_out_ready) begin
            if (w_cnt_i == N_OUT-1) begin
              r_cnt  <= '0;
              r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    o_out_data = '0;
    if (r_state == S_EMIT && w_cnt_i < N_OUT)
      o_out_data = r_q[ACTW'(r_cnt)];
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_in_ready  = (r_state == S_LOAD);
  assign o_out_valid = (r_state == S_EMIT);
  assign o_out_last  = (r_state == S_EMIT) && (w_cnt_i == N_OUT-1);
  assign o_action    = r_action;
  assign o_done      = r_done;
  assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_dqn_fwd_engine.sv
// Directed bench for dqn_fwd_engine: linear-output and ReLU-output instances run in lockstep.
module tb_dqn_fwd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_wr_en = 1'b0;
  logic [6:0]        i_wr_addr = '0;
  logic signed [15:0] i_wr_data = '0;
  logic              i_start = 1'b0;
  logic              i_in_valid = 1'b0;
  logic signed [15:0] i_in_data = '0;
  logic              i_out_ready = 1'b0;

  logic              o_wr_err0, o_busy0, o_in_ready0, o_out_valid0, o_out_last0, o_done0;
  logic signed [15:0] o_out_data0;
  logic [1:0]        o_action0;
  logic              o_wr_err1, o_busy1, o_in_ready1, o_out_valid1, o_out_last1, o_done1;
  logic signed [15:0] o_out_data1;
  logic [1:0]        o_action1;

  dqn_fwd_engine u_dut0 (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_err(o_wr_err0),
    .i_start(i_start), .o_busy(o_busy0),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready0), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid0), .i_out_ready(i_out_ready), .o_out_data(o_out_data0),
    .o_out_last(o_out_last0), .o_action(o_action0), .o_done(o_done0)
  );

  dqn_fwd_engine #(.OUT_ACT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_err(o_wr_err1),
    .i_start(i_start), .o_busy(o_busy1),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready1), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid1), .i_out_ready(i_out_ready), .o_out_data(o_out_data1),
    .o_out_last(o_out_last1), .o_action(o_action1), .o_done(o_done1)
  );

  typedef struct {
    int w2; int b2; int x;
    int w3[4]; int b3[4];
    int stall;
    int eq0[4]; int ea0;
    int eq1[4]; int ea1;
  } vec_t;

  vec_t tv[5];
  int   checks = 0;
  int   errors = 0;
  int   got0[4], got1[4];
  int   lat, act0, act1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    i_wr_en   = 1'b1;
    i_wr_addr = 7'(a);
    i_wr_data = 16'(d);
    tick;
    i_wr_en   = 1'b0;
  endtask

  task automatic load(input int v);
    for (int h = 0; h < 5; h++)
      for (int i = 0; i < 9; i++) wr(h*9 + i, tv[v].w2);
    for (int h = 0; h < 5; h++) wr(45 + h, tv[v].b2);
    for (int k = 0; k < 4; k++)
      for (int h = 0; h < 5; h++) wr(50 + k*5 + h, tv[v].w3[k]);
    for (int k = 0; k < 4; k++) wr(70 + k, tv[v].b3[k]);
  endtask

  task automatic feed(input int xv);
    for (int n = 0; n < 9; n++) begin
      i_in_valid = 1'b1;
      i_in_data  = 16'(xv);
      chk($sformatf("in_ready[%0d]", n), int'(o_in_ready0), 1);
      tick;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic collect(input int v, input int stall_beat);
    lat = 0;
    while (!o_out_valid0 && lat < 300) begin
      tick;
      lat++;
    end
    act0 = int'(o_action0);
    act1 = int'(o_action1);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        i_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick;
          chk($sformatf("v%0d stall valid", v), int'(o_out_valid0), 1);
          chk($sformatf("v%0d stall data", v), int'(o_out_data0), tv[v].eq0[b]);
          chk($sformatf("v%0d stall last", v), int'(o_out_last0), (b == 3) ? 1 : 0);
          chk($sformatf("v%0d stall done", v), int'(o_done0), 0);
        end
      end
      i_out_ready = 1'b1;
      chk($sformatf("v%0d beat%0d valid", v, b), int'(o_out_valid0), 1);
      chk($sformatf("v%0d beat%0d last", v, b), int'(o_out_last0), (b == 3) ? 1 : 0);
      chk($sformatf("v%0d beat%0d done", v, b), int'(o_done0), 0);
      got0[b] = int'(o_out_data0);
      got1[b] = int'(o_out_data1);
      tick;
    end
    i_out_ready = 1'b0;
    chk($sformatf("v%0d done pulse", v), int'(o_done0), 1);
    chk($sformatf("v%0d idle busy", v), int'(o_busy0), 0);
    chk($sformatf("v%0d idle valid", v), int'(o_out_valid0), 0);
    tick;
    chk($sformatf("v%0d done cleared", v), int'(o_done0), 0);
  endtask

  task automatic verify(input int v);
    chk($sformatf("v%0d latency", v), lat, 83);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d lin q%0d", v, k), got0[k], tv[v].eq0[k]);
      chk($sformatf("v%0d relu q%0d", v, k), got1[k], tv[v].eq1[k]);
    end
    chk($sformatf("v%0d lin action", v), act0, tv[v].ea0);
    chk($sformatf("v%0d relu action", v), act1, tv[v].ea1);
    chk($sformatf("v%0d action held", v), int'(o_action0), tv[v].ea0);
  endtask

  task automatic run(input int v, input int stall_beat);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    feed(tv[v].x);
    collect(v, stall_beat);
    verify(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv[0] = '{0, 1024, 1, '{512, 512, 512, 512}, '{0, 0, 0, 0}, -1,
              '{2560, 2560, 2560, 2560}, 0, '{2560, 2560, 2560, 2560}, 0};
    tv[1] = '{0, -1024, 77, '{512, 512, 512, 512}, '{0, 100, 200, 300}, 2,
              '{0, 100, 200, 300}, 3, '{0, 100, 200, 300}, 3};
    tv[2] = '{32767, 0, 32767, '{1024, 0, 0, 0}, '{0, 0, 0, 0}, -1,
              '{32767, 0, 0, 0}, 0, '{32767, 0, 0, 0}, 0};
    tv[3] = '{32767, 0, 32767, '{1024, -1024, 0, 0}, '{0, 0, 0, 0}, -1,
              '{32767, -32768, 0, 0}, 0, '{32767, 0, 0, 0}, 0};
    tv[4] = '{512, -1000, 300, '{1024, -1024, 2048, -3}, '{0, 0, -100, 0}, 1,
              '{1750, -1750, 3400, -6}, 2, '{1750, 0, 3400, 0}, 2};

    repeat (3) tick;
    chk("rst busy", int'(o_busy0), 0);
    chk("rst in_ready", int'(o_in_ready0), 0);
    chk("rst out_valid", int'(o_out_valid0), 0);
    chk("rst out_last", int'(o_out_last0), 0);
    chk("rst done", int'(o_done0), 0);
    chk("rst wr_err", int'(o_wr_err0), 0);
    chk("rst out_data", int'(o_out_data0), 0);
    chk("rst action", int'(o_action0), 0);
    chk("rst1 flags", int'({o_busy1, o_in_ready1, o_out_valid1, o_out_last1, o_done1, o_wr_err1}), 0);
    chk("rst1 data", int'(o_out_data1), 0);
    chk("rst1 action", int'(o_action1), 0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 5; v++) begin
      load(v);
      chk($sformatf("v%0d idle write no err", v), int'(o_wr_err0), 0);
      run(v, tv[v].stall);
    end

    // Abort mid hidden layer, then rerun on retained weights.
    load(0);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    feed(5);
    repeat (20) tick;
    chk("mid-hid busy", int'(o_busy0), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", int'(o_busy0), 0);
    chk("abort out_valid", int'(o_out_valid0), 0);
    chk("abort in_ready", int'(o_in_ready0), 0);
    run(0, -1);

    // Write while busy is dropped and flagged for one cycle.
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    i_wr_en = 1'b1;
    i_wr_addr = 7'd45;
    i_wr_data = -16'sd5000;
    tick;
    i_wr_en = 1'b0;
    chk("busy write err pulse", int'(o_wr_err0), 1);
    tick;
    chk("busy write err clear", int'(o_wr_err0), 0);
    feed(1);
    collect(0, -1);
    verify(0);

    // Address past the map in IDLE: ignored silently.
    wr(100, 7777);
    chk("oob write no err", int'(o_wr_err0), 0);
    run(0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dqn_fwd_engine.md
Name: dqn_fwd_engine

Overview:
Parametrised, time-multiplexed forward-propagation engine for the DQN Q-network (input → hidden → output). It has one multiply-accumulate (MAC) datapath and an internal weight/bias store. An FSM sequences the store, a streamed input vector, the hidden layer with ReLU, and the output layer. It emits Q-values on a valid/ready stream, together with the greedy action (argmax), for the agent's action-select logic. It generalises the fixed 9-5-4 forward path to arbitrary layer sizes, adds an input/output handshake, saturating fixed-point arithmetic and a selectable output activation.

Parameters:
N_IN, 9, input vector length
N_HID, 5, hidden neurons
N_OUT, 4, output neurons (actions)
DW, 16, signed data/weight width
FRAC, 10, fraction bits (Q(DW-FRAC).FRAC)
ACC_W, 40, accumulator width (≥ 2*DW + clog2(max(N_IN,N_HID)+1))
OUT_ACT, 0, output activation: 0 linear, 1 ReLU
AW, derived, clog2(N_HID*N_IN + N_HID + N_OUT*N_HID + N_OUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  weight/bias store write strobe
wr_addr  in  AW  store address (map below)
wr_data  in  DW  signed write value
wr_err  out  1  one-cycle pulse: write attempted while busy
start  in  1  begin inference (sampled in IDLE only)
busy  out  1  high in every state except IDLE
in_valid  in  1  input sample valid
in_ready  out  1  high only in LOAD
in_data  in  DW  signed input sample, index 0 first
out_valid  out  1  Q-value valid
out_ready  in  1  consumer ready
out_data  out  DW  Q-value, index 0 first
out_last  out  1  high with the final Q-value (index N_OUT-1)
action  out  clog2(N_OUT)  argmax index, stable from first out_valid until next start
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (rst=1 at posedge): state → IDLE. busy, in_ready, out_valid, out_last, done and wr_err = 0. out_data and action = 0. The input buffer and hidden activations are cleared. The weight/bias store is not reset and retains its contents.
- Store address map:
  - W2[h][i] at h*N_IN+i
  - B2[h] at N_HID*N_IN+h
  - W3[k][h] at N_HID*N_IN+N_HID+k*N_HID+h
  - B3[k] follows W3.
  - Addresses beyond the map are ignored.
- Writes take effect only in IDLE, on the cycle of wr_en. A write while busy is dropped and pulses wr_err on the next cycle.
- FSM:
  - IDLE: start=1 → LOAD.
  - LOAD: in_ready=1. Each in_valid&in_ready stores in_data at index n, n=0..N_IN-1. After the N_IN-th handshake → HID.
  - HID: for each neuron h:
    - first cycle: acc = sign-extended B2[h] << FRAC;
    - next N_IN cycles: acc += W2[h][i]*x[i];
    - one write-back cycle: a2[h] = ReLU(sat(acc >>> FRAC)).
    - After neuron N_HID-1 → OUT.
  - OUT: same MAC sequence over a2 with W3/B3. Write-back is q[k] = sat(acc >>> FRAC), ReLU applied only if OUT_ACT=1. The argmax is updated at each write-back. Strict greater-than is used, so ties resolve to the lowest index. After k=N_OUT-1 → EMIT.
  - EMIT: present q[0..N_OUT-1] in order with out_valid=1. out_data/out_last hold while out_ready=0. On the last handshake → IDLE with done=1 for one cycle.
- Arithmetic rules:
  - Products are full 2*DW signed, sign-extended into ACC_W.
  - >>> FRAC is arithmetic (floor), no rounding.
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
  - The accumulator never wraps for the stated ACC_W.
- Timing (no stalls): cycles from the last input handshake to first out_valid = N_HID*(N_IN+2) + N_OUT*(N_HID+2). Default: 55+28=83.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.
- rst mid-operation aborts immediately. The next start recomputes from a fresh input vector using the retained weights.

Test Plan:
- Default params, all W2=0, B2=1024 (1.0), W3=512 (0.5), B3=0, any input → q0..q3=2560 each, action=0 (tie), out_last on 4th beat, done one cycle after.
- W2=0, B2=-1024 (ReLU→0), B3=0,100,200,300 → q=0,100,200,300, action=3. First out_valid exactly 83 cycles after the 9th input handshake.
- Saturation: x[i]=32767, W2=32767, B2=0 → a2=32767. W3[0][*]=1024, others 0, B3=0 → q0=32767, q1..q3=0. Repeat with W3[1][*]=-1024, OUT_ACT=1 → q1=0.
- Backpressure: out_ready low for 5 cycles on beat 2 → out_data/out_last/out_valid held unchanged, no beat lost or duplicated, done only after 4th handshake.
- rst asserted mid-HID → next cycle busy=0, out_valid=0. A rerun with the same input matches the first scenario's values with no reload.
- wr_en during busy → store unchanged (result identical to baseline), wr_err=1 for exactly one cycle. Write in IDLE to address beyond map → no effect, no wr_err.
